crypto_reg_file: RTL and testbench
==================================

# crypto_reg_file

Parametrised general-purpose and key register file for the crypto processor datapath. It provides two independent registered read ports, one write port with write-first bypass, per-register sticky write-lock bits for key material, and a hardware zeroize sequencer that clears every register and lock bit, one per cycle. It sits between the instruction decoder and the ALU/cipher units and replaces the single-port 8x16 bank.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; depth DEPTH = 2**ADDR_W (local, derived)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- rd_en_a  in  1  read request, port A
- rd_addr_a  in  ADDR_W  read address, port A
- rd_data_a  out  DATA_W  registered read data, port A
- rd_en_b  in  1  read request, port B
- rd_addr_b  in  ADDR_W  read address, port B
- rd_data_b  out  DATA_W  registered read data, port B
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- lock_en  in  1  set the lock bit of lock_addr
- lock_addr  in  ADDR_W  register to lock
- zeroize_req  in  1  start clear sequence (level sampled)
- busy  out  1  zeroize sequence in progress
- wr_err  out  1  one-cycle pulse: a write was rejected

## Operation
- Reset (async assert): all registers 0, all lock bits 0, rd_data_a/b 0, busy 0, wr_err 0, FSM IDLE, clear counter 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when zeroize_req=1 at a clock edge.
  - CLEAR: each cycle clears register[cnt] and lock[cnt], cnt increments; after clearing index DEPTH-1, cnt returns to 0 and FSM goes to IDLE.
  - zeroize_req while in CLEAR is ignored; it does not restart or extend the sequence.
- Write: accepted when wr_en=1, FSM in IDLE, lock[wr_addr]=0. Register updates at that edge.
- Rejected write (wr_en=1 and either locked or CLEAR): no state change; wr_err=1 for exactly the next cycle. wr_err is otherwise 0.
- Lock: when lock_en=1 in IDLE, lock[lock_addr] is set at the edge. Lock bits clear only via reset or zeroize. lock_en in CLEAR is ignored.
- Simultaneous write and lock to the same address: write is accepted; the lock applies from the next cycle.
- zeroize_req and an accepted write in the same IDLE cycle: the write lands, then the sequence clears it.
- Read, per port independently: when rd_en=1, rd_data is updated at the edge; when rd_en=0, rd_data holds.
  - In IDLE, the value loaded is register[rd_addr], except with write-first bypass: if an accepted write to the same address happens in the same cycle, wr_data is loaded.
  - In CLEAR, the value loaded is 0.
- Both ports may read the same address in the same cycle with no conflict.
- Locked registers remain readable.

## Timing
- Read latency: 1 cycle (address and enable at edge N, data valid after edge N).
- Write-to-read: same-cycle bypass, so there are zero dead cycles.
- busy rises at the edge that samples zeroize_req and stays high for exactly DEPTH cycles. The first write accepted is at the edge after busy falls.
- wr_err is registered and asserted for the cycle following the rejected request.
- Reset mid-CLEAR: immediate return to IDLE with everything zero, and the sequence is not resumed.

## Test plan
- Reset, then read addresses 0-7 on both ports -> all rd_data 0, busy 0, wr_err 0.
- Write 0xA5A5 to r3 with rd_en_a=1, rd_addr_a=3 in the same cycle -> rd_data_a=0xA5A5 after 1 edge (bypass); port B reading r3 on the next cycle -> 0xA5A5.
- Write 0x1234 to r5, lock r5, write 0xFFFF to r5 -> wr_err pulses for 1 cycle, r5 reads 0x1234; write r6 unaffected.
- Fill r0-r7 with 0x0101*(i+1), lock r2, pulse zeroize_req -> busy high for 8 cycles, reads during busy return 0, writes during busy give wr_err, and afterward all regs read 0 and a write to r2 is accepted.
- Assert rst at the 4th CLEAR cycle -> busy 0 immediately, all outputs 0; zeroize_req held high for 20 cycles -> busy high for 8 cycles, low for 1 cycle, high for 8 again (re-trigger only from IDLE).

Source files
------------

// File: rtl/crypto_reg_file.sv
// Crypto datapath register file: two registered read ports, one write port with
// write-first bypass, sticky per-register write locks and a one-per-cycle zeroize sweep.
module crypto_reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic              zeroize_req,
  output logic              busy,
  output logic              wr_err
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  lock;
  logic              wr_ok;

  assign busy  = (state == CLEAR);
  assign wr_ok = wr_en && (state == IDLE) && !lock[wr_addr];

  // Value a read port loads this edge: zero while sweeping, else bypassed or stored data.
  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    if (state == CLEAR)           return '0;
    else if (wr_ok && wr_addr == a) return wr_data;
    else                          return regs[a];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE:  if (zeroize_req) state <= CLEAR;
        CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == ADDR_W'(DEPTH-1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A lock set alongside a write to the same register checks the old bit, so the write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  lock <= '0;
    else if (state == CLEAR)  lock[cnt] <= 1'b0;
    else if (lock_en)         lock[lock_addr] <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      wr_err    <= 1'b0;
    end else begin
      if (rd_en_a) rd_data_a <= rd_val(rd_addr_a);
      if (rd_en_b) rd_data_b <= rd_val(rd_addr_b);
      wr_err <= wr_en && !wr_ok;
    end
  end
endmodule

// File: tb/tb_crypto_reg_file.sv
// Self-checking bench for crypto_reg_file: directed scenarios plus random traffic
// compared against a behavioural array model.
module tb_crypto_reg_file;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_en_a, rd_en_b, wr_en, lock_en, zeroize_req;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr, lock_addr;
  logic [DATA_W-1:0] wr_data, rd_data_a, rd_data_b;
  logic              busy, wr_err;

  int checks = 0;
  int failures = 0;

  // reference model
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_lock [DEPTH];
  int                m_left;   // clear cycles still to run, 0 when idle
  int                m_idx;
  logic [DATA_W-1:0] e_a, e_b;
  logic              e_err, e_busy;

  crypto_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .zeroize_req(zeroize_req), .busy(busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_lock[i] = 1'b0;
    end
    m_left = 0; m_idx = 0;
    e_a = '0; e_b = '0; e_err = 1'b0; e_busy = 1'b0;
  endtask

  task automatic idle_inputs();
    rd_en_a = 0; rd_en_b = 0; wr_en = 0; lock_en = 0; zeroize_req = 0;
    rd_addr_a = 0; rd_addr_b = 0; wr_addr = 0; lock_addr = 0; wr_data = 0;
  endtask

  // Advance the model with the current inputs, then clock the DUT and settle.
  task automatic tick();
    bit idle, acc;
    idle = (m_left == 0);
    acc  = wr_en && idle && !m_lock[wr_addr];
    e_err = wr_en && !acc;
    if (rd_en_a) e_a = !idle ? '0 : (acc && wr_addr == rd_addr_a) ? wr_data : m_mem[rd_addr_a];
    if (rd_en_b) e_b = !idle ? '0 : (acc && wr_addr == rd_addr_b) ? wr_data : m_mem[rd_addr_b];
    if (idle) begin
      if (acc) m_mem[wr_addr] = wr_data;
      if (lock_en) m_lock[lock_addr] = 1'b1;
      if (zeroize_req) begin m_left = DEPTH; m_idx = 0; end
    end else begin
      m_mem[m_idx] = '0;
      m_lock[m_idx] = 1'b0;
      m_idx++;
      m_left--;
    end
    e_busy = (m_left != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    checks++;
    if (busy !== 1'b0 || wr_err !== 1'b0 || rd_data_a !== '0 || rd_data_b !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b wr_err=%b a=%h b=%h want all 0", busy, wr_err, rd_data_a, rd_data_b);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_en_a = 1; rd_en_b = 1; rd_addr_a = i[ADDR_W-1:0]; rd_addr_b = 3'(DEPTH-1-i);
      tick();
      checks++;
      if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0 || busy !== 1'b0 || wr_err !== 1'b0) begin
        failures++;
        $display("FAIL reset_read[%0d] a=%h b=%h busy=%b err=%b want 0", i, rd_data_a, rd_data_b, busy, wr_err);
      end
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    idle_inputs();
    wr_en = 1; wr_addr = 3; wr_data = 16'hA5A5; rd_en_a = 1; rd_addr_a = 3;
    tick();
    checks++;
    if (rd_data_a !== 16'hA5A5) begin
      failures++;
      $display("FAIL bypass_a got=%h want=a5a5", rd_data_a);
    end
    idle_inputs();
    rd_en_b = 1; rd_addr_b = 3;
    tick();
    checks++;
    if (rd_data_b !== 16'hA5A5 || rd_data_a !== 16'hA5A5) begin
      failures++;
      $display("FAIL readback_b b=%h a(held)=%h want a5a5", rd_data_b, rd_data_a);
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    idle_inputs();
    wr_en = 1; wr_addr = 5; wr_data = 16'h1234;
    tick();
    idle_inputs();
    lock_en = 1; lock_addr = 5;
    tick();
    idle_inputs();
    wr_en = 1; wr_addr = 5; wr_data = 16'hFFFF;
    tick();
    checks++;
    if (wr_err !== 1'b1) begin
      failures++;
      $display("FAIL lock_err got=%b want=1", wr_err);
    end
    idle_inputs();
    rd_en_a = 1; rd_addr_a = 5;
    tick();
    checks++;
    if (wr_err !== 1'b0 || rd_data_a !== 16'h1234) begin
      failures++;
      $display("FAIL lock_hold err=%b r5=%h want 0/1234", wr_err, rd_data_a);
    end
    idle_inputs();
    wr_en = 1; wr_addr = 6; wr_data = 16'hBEEF;
    tick();
    idle_inputs();
    rd_en_b = 1; rd_addr_b = 6;
    tick();
    checks++;
    if (rd_data_b !== 16'hBEEF || wr_err !== 1'b0) begin
      failures++;
      $display("FAIL unlocked_r6 r6=%h err=%b want beef/0", rd_data_b, wr_err);
    end
    idle_inputs();
  endtask

  task automatic test_zeroize();
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1; wr_addr = i[ADDR_W-1:0]; wr_data = 16'h0101 * 16'(i + 1);
      tick();
    end
    idle_inputs();
    lock_en = 1; lock_addr = 2;
    tick();
    idle_inputs();
    zeroize_req = 1;
    tick();
    for (int c = 0; c < DEPTH; c++) begin
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL zeroize_busy[%0d] got=%b want=1", c, busy);
      end
      if (c > 0) begin
        checks++;
        if (rd_data_a !== 16'h0 || wr_err !== 1'b1) begin
          failures++;
          $display("FAIL zeroize_rd_wr[%0d] a=%h err=%b want 0/1", c, rd_data_a, wr_err);
        end
      end
      idle_inputs();
      rd_en_a = 1; rd_addr_a = 3'(7 - c);
      wr_en = 1; wr_addr = c[ADDR_W-1:0]; wr_data = 16'hDEAD;
      tick();
    end
    checks++;
    if (busy !== 1'b0 || wr_err !== 1'b1 || rd_data_a !== 16'h0) begin
      failures++;
      $display("FAIL zeroize_end busy=%b err=%b a=%h want 0/1/0", busy, wr_err, rd_data_a);
    end
    idle_inputs();
    wr_en = 1; wr_addr = 2; wr_data = 16'h7777;
    tick();
    checks++;
    if (wr_err !== 1'b0) begin
      failures++;
      $display("FAIL zeroize_unlock err=%b want 0", wr_err);
    end
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      rd_en_a = 1; rd_addr_a = i[ADDR_W-1:0]; rd_en_b = 1; rd_addr_b = i[ADDR_W-1:0];
      tick();
      checks++;
      if (rd_data_a !== (i == 2 ? 16'h7777 : 16'h0) || rd_data_b !== rd_data_a) begin
        failures++;
        $display("FAIL post_zeroize[%0d] a=%h b=%h want %h", i, rd_data_a, rd_data_b, (i == 2 ? 16'h7777 : 16'h0));
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    wr_en = 1; wr_addr = 1; wr_data = 16'h4242; rd_en_a = 1; rd_addr_a = 1;
    tick();
    idle_inputs();
    zeroize_req = 1;
    tick();
    idle_inputs();
    wr_en = 1;
    for (int c = 0; c < 3; c++) tick();
    #2 rst = 1;
    #1;
    model_reset();
    checks++;
    if (busy !== 1'b0 || wr_err !== 1'b0 || rd_data_a !== '0 || rd_data_b !== '0) begin
      failures++;
      $display("FAIL mid_clear_reset busy=%b err=%b a=%h b=%h want 0", busy, wr_err, rd_data_a, rd_data_b);
    end
    idle_inputs();
    #2 rst = 0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL no_resume busy=%b want 0", busy);
    end
    zeroize_req = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (busy !== (((i - 1) % 9) != 8)) begin
        failures++;
        $display("FAIL retrigger[%0d] busy=%b want %b", i, busy, (((i - 1) % 9) != 8));
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rd_en_a = 1'($urandom); rd_addr_a = 3'($urandom);
      rd_en_b = 1'($urandom); rd_addr_b = 3'($urandom);
      wr_en = ($urandom_range(0, 3) != 0); wr_addr = 3'($urandom); wr_data = 16'($urandom);
      lock_en = ($urandom_range(0, 15) == 0); lock_addr = 3'($urandom);
      zeroize_req = ($urandom_range(0, 40) == 0);
      tick();
      checks++;
      if (rd_data_a !== e_a || rd_data_b !== e_b || busy !== e_busy || wr_err !== e_err) begin
        failures++;
        $display("FAIL random[%0d] a=%h/%h b=%h/%h busy=%b/%b err=%b/%b (got/want)",
                 n, rd_data_a, e_a, rd_data_b, e_b, busy, e_busy, wr_err, e_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1;
    #22 rst = 0;
    @(posedge clk); #1;
    test_reset();
    test_bypass();
    test_lock();
    test_zeroize();
    test_reset_mid_clear();
    tick();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
